decode_stage: RTL and testbench

Parametrised RV32I/RV32E decode stage between the AXI4-Lite instruction read channel and the execute unit. Buffers fetched words in a FIFO, decodes the head instruction, reads operands from an internal register file with write-back bypass, and holds issue on RAW/WAW hazards using a per-register busy scoreboard. Supports pipeline flush and illegal-instruction flagging.

---
 rtl/rv32_pkg.sv | 85 ++++++++
 rtl/decode_stage_if.sv | 45 ++++
 rtl/instr_fifo.sv | 53 +++++
 rtl/decode_stage.sv | 132 +++++++++++++
 tb/tb_decode_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 decode definitions: opcodes, instruction formats, source/destination
// usage per format and immediate extraction helpers.
package rv32_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;

   typedef struct packed {
      logic rs1;
      logic rs2;
      logic rd;
   } src_use_t;

   // FENCE, SYSTEM and unknown opcodes all fall into FMT_NONE.
   function automatic fmt_e opcode_fmt(input logic [6:0] op);
      case (op)
         OP_R:                      return FMT_R;
         OP_IMM, OP_LOAD, OP_JALR:  return FMT_I;
         OP_STORE:                  return FMT_S;
         OP_BRANCH:                 return FMT_B;
         OP_LUI, OP_AUIPC:          return FMT_U;
         OP_JAL:                    return FMT_J;
         default:                   return FMT_NONE;
      endcase
   endfunction

   function automatic logic opcode_known(input logic [6:0] op);
      return op inside {OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH,
                        OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE, OP_SYSTEM};
   endfunction

   function automatic src_use_t fmt_usage(input fmt_e f);
      case (f)
         FMT_R:        return '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
         FMT_I:        return '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
         FMT_S, FMT_B: return '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
         FMT_U, FMT_J: return '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
         default:      return '{rs1: 1'b0, rs2: 1'b0, rd: 1'b0};
      endcase
   endfunction

   function automatic logic [31:0] imm_i(input logic [31:0] i);
      return {{20{i[31]}}, i[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] i);
      return {{20{i[31]}}, i[31:25], i[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] i);
      return {i[31:12], 12'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   // R-type and operand-less formats carry no immediate.
   function automatic logic [31:0] imm_sel(input fmt_e f, input logic [31:0] i);
      case (f)
         FMT_I:   return imm_i(i);
         FMT_S:   return imm_s(i);
         FMT_B:   return imm_b(i);
         FMT_U:   return imm_u(i);
         FMT_J:   return imm_j(i);
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode stage bus: fetch channel, issue channel to execute, write-back and flush.
// slave = the decode stage, master = the surrounding fetch/execute environment.
interface decode_stage_if #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2
);
   localparam int LVLW = $clog2(FIFO_DEPTH + 1);

   logic            i_im_rvalid;
   logic            o_im_rready;
   logic [XLEN-1:0] i_im_rdata;

   logic            o_du_valid;
   logic            i_ex_ready;
   logic [6:0]      o_opcode;
   logic [6:0]      o_funct7;
   logic [2:0]      o_funct3;
   logic [XLEN-1:0] o_immediate;
   logic [XLEN-1:0] o_rs1_rdata;
   logic [XLEN-1:0] o_rs2_rdata;
   logic [4:0]      o_rd_waddr;
   logic            o_rd_wen;
   logic            o_illegal;

   logic            i_rf_rd_wvalid;
   logic [4:0]      i_rf_rd_waddr;
   logic [XLEN-1:0] i_rf_rd_wdata;

   logic            i_flush;
   logic [LVLW-1:0] o_fifo_level;

   modport slave (
      input  i_im_rvalid, i_im_rdata, i_ex_ready,
      input  i_rf_rd_wvalid, i_rf_rd_waddr, i_rf_rd_wdata, i_flush,
      output o_im_rready, o_du_valid, o_opcode, o_funct7, o_funct3, o_immediate,
      output o_rs1_rdata, o_rs2_rdata, o_rd_waddr, o_rd_wen, o_illegal, o_fifo_level
   );

   modport master (
      output i_im_rvalid, i_im_rdata, i_ex_ready,
      output i_rf_rd_wvalid, i_rf_rd_waddr, i_rf_rd_wdata, i_flush,
      input  o_im_rready, o_du_valid, o_opcode, o_funct7, o_funct3, o_immediate,
      input  o_rs1_rdata, o_rs2_rdata, o_rd_waddr, o_rd_wen, o_illegal, o_fifo_level
   );
endinterface

// File: rtl/instr_fifo.sv
// Instruction word FIFO with registered occupancy. A push while full is legal only
// when a pop happens in the same cycle; the caller guarantees this.
module instr_fifo #(
   parameter int DEPTH = 2,
   parameter int DLEN  = 32
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flush,
   input  logic                         push,
   input  logic                         pop,
   input  logic [DLEN-1:0]              din,
   output logic [DLEN-1:0]              dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [DLEN-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [LW-1:0]   count;

   // Storage write.
   // NOTE: the data array has no reset; pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy update; flush empties the FIFO on the next edge.
   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + LW'(push) - LW'(pop);
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);
   assign level = count;
endmodule

// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: buffers fetched words, decodes the FIFO head, reads
// operands with write-back bypass and holds issue on RAW/WAW via a busy scoreboard.
module decode_stage
   import rv32_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int NREGS      = 32
) (
   input logic         clk,
   input logic         rstn,
   decode_stage_if.slave bus
);
   localparam int RW = $clog2(NREGS);

   logic [XLEN-1:0]  head;
   logic             fifo_full, fifo_empty, push, pop;
   logic [XLEN-1:0]  rf [NREGS];
   logic [NREGS-1:0] busy, set_mask, clr_mask;

   logic [6:0]       opcode;
   logic [4:0]       rs1, rs2, rd;
   fmt_e             fmt;
   src_use_t         uses;
   logic             illegal, u_rs1, u_rs2, u_rd, rd_wen;
   logic             wb_en, wb_hit1, wb_hit2, hazard, can_issue;
   logic [XLEN-1:0]  imm, op1, op2;

   instr_fifo #(.DEPTH(FIFO_DEPTH), .DLEN(XLEN)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .flush (bus.i_flush),
      .push  (push),
      .pop   (pop),
      .din   (bus.i_im_rdata),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (bus.o_fifo_level)
   );

   assign opcode = head[6:0];
   assign rd     = head[11:7];
   assign rs1    = head[19:15];
   assign rs2    = head[24:20];

   // Write-backs to x0, or beyond the implemented register count, are ignored.
   assign wb_en   = bus.i_rf_rd_wvalid && (bus.i_rf_rd_waddr != 5'd0) &&
                    ((NREGS == 32) || !bus.i_rf_rd_waddr[4]);
   assign wb_hit1 = wb_en && (bus.i_rf_rd_waddr == rs1);
   assign wb_hit2 = wb_en && (bus.i_rf_rd_waddr == rs2);

   // Decode of the head word: legality, register usage, hazard and operand values.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      fmt     = opcode_fmt(opcode);
      uses    = fmt_usage(fmt);
      illegal = !opcode_known(opcode);
      if (NREGS < 32)
         illegal = illegal | (uses.rs1 & rs1[4]) | (uses.rs2 & rs2[4]) | (uses.rd & rd[4]);
      u_rs1  = uses.rs1 & !illegal;
      u_rs2  = uses.rs2 & !illegal;
      u_rd   = uses.rd  & !illegal;
      rd_wen = u_rd && (rd != 5'd0);
      imm    = illegal ? '0 : XLEN'(imm_sel(fmt, head[31:0]));
      hazard = (u_rs1 && (rs1 != 5'd0) && busy[rs1[RW-1:0]] && !wb_hit1) ||
               (u_rs2 && (rs2 != 5'd0) && busy[rs2[RW-1:0]] && !wb_hit2) ||
               (u_rd  && busy[rd[RW-1:0]]);
      op1 = '0;
      if (u_rs1 && (rs1 != 5'd0)) op1 = wb_hit1 ? bus.i_rf_rd_wdata : rf[rs1[RW-1:0]];
      op2 = '0;
      if (u_rs2 && (rs2 != 5'd0)) op2 = wb_hit2 ? bus.i_rf_rd_wdata : rf[rs2[RW-1:0]];
   end

   assign can_issue       = !fifo_empty && (!bus.o_du_valid || bus.i_ex_ready) &&
                            !hazard && !bus.i_flush;
   assign pop             = can_issue;
   // A pop while full frees a slot in the same cycle; held closed during reset.
   assign bus.o_im_rready = rstn && (!fifo_full || can_issue);
   assign push            = bus.i_im_rvalid && bus.o_im_rready && !bus.i_flush;

   // Issuing an instruction marks its rd busy; this set overrides a same-cycle clear.
   assign set_mask = (can_issue && rd_wen) ? (NREGS'(1) << rd[RW-1:0]) : '0;
   assign clr_mask = wb_en ? (NREGS'(1) << bus.i_rf_rd_waddr[RW-1:0]) : '0;

   // Issue register: loads on issue, holds until execute accepts, drops on flush.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.o_du_valid  <= 1'b0;
         bus.o_opcode    <= '0;
         bus.o_funct7    <= '0;
         bus.o_funct3    <= '0;
         bus.o_immediate <= '0;
         bus.o_rs1_rdata <= '0;
         bus.o_rs2_rdata <= '0;
         bus.o_rd_waddr  <= '0;
         bus.o_rd_wen    <= 1'b0;
         bus.o_illegal   <= 1'b0;
      end else if (bus.i_flush) begin
         bus.o_du_valid  <= 1'b0;
      end else if (can_issue) begin
         bus.o_du_valid  <= 1'b1;
         bus.o_opcode    <= opcode;
         bus.o_funct7    <= head[31:25];
         bus.o_funct3    <= head[14:12];
         bus.o_immediate <= imm;
         bus.o_rs1_rdata <= op1;
         bus.o_rs2_rdata <= op2;
         bus.o_rd_waddr  <= u_rd ? rd : 5'd0;
         bus.o_rd_wen    <= rd_wen;
         bus.o_illegal   <= illegal;
      end else if (bus.i_ex_ready) begin
         bus.o_du_valid  <= 1'b0;
      end
   end

   // Busy scoreboard; x0 is never set because rd_wen excludes it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)            busy <= '0;
      else if (bus.i_flush) busy <= '0;
      else                  busy <= (busy & ~clr_mask) | set_mask;
   end

   // Register file write-back; still applied during a flush cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < NREGS; r++) rf[r] <= '0;
      end else if (wb_en) begin
         rf[bus.i_rf_rd_waddr[RW-1:0]] <= bus.i_rf_rd_wdata;
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for single-instruction decode plus
// hand-written sequences for stall, back-pressure, flush, RV32E and async reset.
module tb_decode_stage;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   decode_stage_if #(.XLEN(32), .FIFO_DEPTH(2)) bus ();
   decode_stage_if #(.XLEN(32), .FIFO_DEPTH(2)) bus_e ();

   decode_stage #(.XLEN(32), .FIFO_DEPTH(2), .NREGS(32)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   decode_stage #(.XLEN(32), .FIFO_DEPTH(2), .NREGS(16)) dut_e (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_e)
   );

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        wen;
      logic        ill;
      logic [31:0] rs1v;
      logic [31:0] rs2v;
      logic [31:0] wb;
   } vec_t;

   vec_t vecs [9];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Offer one word until accepted; returns at the negedge after the accepting edge.
   task automatic push_word(input logic [31:0] w);
      bit ok = 1'b0;
      bus.i_im_rvalid = 1'b1;
      bus.i_im_rdata  = w;
      for (int k = 0; k < 50 && !ok; k++) begin
         #1;
         ok = bus.o_im_rready;
         @(negedge clk);
      end
      bus.i_im_rvalid = 1'b0;
      if (!ok) check("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_valid(input int max, input string name);
      int k = 0;
      while (!bus.o_du_valid && k < max) begin
         @(negedge clk);
         k++;
      end
      if (!bus.o_du_valid) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic writeback(input logic [4:0] a, input logic [31:0] d);
      bus.i_rf_rd_wvalid = 1'b1;
      bus.i_rf_rd_waddr  = a;
      bus.i_rf_rd_wdata  = d;
      @(negedge clk);
      bus.i_rf_rd_wvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{32'h00500093, 7'h13, 3'd0, 7'h00, 32'h00000005, 5'd1, 1'b1, 1'b0, 32'h0,   32'h0,   32'h100};
      vecs[1] = '{32'hFFF00113, 7'h13, 3'd0, 7'h7F, 32'hFFFFFFFF, 5'd2, 1'b1, 1'b0, 32'h0,   32'h0,   32'h101};
      vecs[2] = '{32'h0220A023, 7'h23, 3'd2, 7'h01, 32'h00000020, 5'd0, 1'b0, 1'b0, 32'h100, 32'h101, 32'h0};
      vecs[3] = '{32'hFE000EE3, 7'h63, 3'd0, 7'h7F, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0, 32'h0,   32'h0,   32'h0};
      vecs[4] = '{32'h123452B7, 7'h37, 3'd5, 7'h09, 32'h12345000, 5'd5, 1'b1, 1'b0, 32'h0,   32'h0,   32'h104};
      vecs[5] = '{32'h008000EF, 7'h6F, 3'd0, 7'h00, 32'h00000008, 5'd1, 1'b1, 1'b0, 32'h0,   32'h0,   32'h105};
      vecs[6] = '{32'hFFFFFFFF, 7'h7F, 3'd7, 7'h7F, 32'h00000000, 5'd0, 1'b0, 1'b1, 32'h0,   32'h0,   32'h0};
      vecs[7] = '{32'h000001B3, 7'h33, 3'd0, 7'h00, 32'h00000000, 5'd3, 1'b1, 1'b0, 32'h0,   32'h0,   32'h107};
      vecs[8] = '{32'hFFFFF217, 7'h17, 3'd7, 7'h7F, 32'hFFFFF000, 5'd4, 1'b1, 1'b0, 32'h0,   32'h0,   32'h108};

      rstn = 1'b0;
      bus.i_im_rvalid = 1'b0;  bus.i_im_rdata = '0;  bus.i_ex_ready = 1'b0;
      bus.i_rf_rd_wvalid = 1'b0;  bus.i_rf_rd_waddr = '0;  bus.i_rf_rd_wdata = '0;
      bus.i_flush = 1'b0;
      bus_e.i_im_rvalid = 1'b0;  bus_e.i_im_rdata = '0;  bus_e.i_ex_ready = 1'b1;
      bus_e.i_rf_rd_wvalid = 1'b0;  bus_e.i_rf_rd_waddr = '0;  bus_e.i_rf_rd_wdata = '0;
      bus_e.i_flush = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_rready", bus.o_im_rready, 0);
      check("rst_du_valid", bus.o_du_valid, 0);
      check("rst_level", bus.o_fifo_level, 0);
      check("rst_rd_wen", bus.o_rd_wen, 0);
      check("rst_illegal", bus.o_illegal, 0);
      check("rst_imm", bus.o_immediate, 0);
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_rready", bus.o_im_rready, 1);

      // Latency, then ADD x2,x1,x1 stalls until the write-back of x1.
      bus.i_ex_ready = 1'b1;
      push_word(32'h00500093);
      check("lat_not_yet", bus.o_du_valid, 0);
      check("lat_level", bus.o_fifo_level, 1);
      push_word(32'h00108133);
      check("lat_valid", bus.o_du_valid, 1);
      check("lat_opcode", bus.o_opcode, 32'h13);
      check("lat_imm", bus.o_immediate, 5);
      check("lat_rd", bus.o_rd_waddr, 1);
      check("lat_rd_wen", bus.o_rd_wen, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("raw_stall%0d", k), bus.o_du_valid, 0);
      end
      writeback(5'd1, 32'd5);
      check("raw_valid", bus.o_du_valid, 1);
      check("raw_opcode", bus.o_opcode, 32'h33);
      check("raw_rs1", bus.o_rs1_rdata, 5);
      check("raw_rs2", bus.o_rs2_rdata, 5);
      check("raw_rd", bus.o_rd_waddr, 2);
      writeback(5'd2, 32'd10);
      writeback(5'd0, 32'hFFFFFFFF);

      // Single-instruction decode table.
      for (int i = 0; i < 9; i++) begin
         push_word(vecs[i].instr);
         wait_valid(8, $sformatf("v%0d", i));
         check($sformatf("v%0d_op", i),   bus.o_opcode,      vecs[i].op);
         check($sformatf("v%0d_f3", i),   bus.o_funct3,      vecs[i].f3);
         check($sformatf("v%0d_f7", i),   bus.o_funct7,      vecs[i].f7);
         check($sformatf("v%0d_imm", i),  bus.o_immediate,   vecs[i].imm);
         check($sformatf("v%0d_rd", i),   bus.o_rd_waddr,    vecs[i].rd);
         check($sformatf("v%0d_wen", i),  bus.o_rd_wen,      vecs[i].wen);
         check($sformatf("v%0d_ill", i),  bus.o_illegal,     vecs[i].ill);
         check($sformatf("v%0d_rs1", i),  bus.o_rs1_rdata,   vecs[i].rs1v);
         check($sformatf("v%0d_rs2", i),  bus.o_rs2_rdata,   vecs[i].rs2v);
         if (vecs[i].wen) writeback(vecs[i].rd, vecs[i].wb);
         else @(negedge clk);
      end

      // Back-pressure: FIFO fills, fetch closes, outputs hold; release drains in order.
      bus.i_ex_ready = 1'b0;
      push_word(32'h00100313);
      push_word(32'h00200393);
      push_word(32'h00300413);
      check("bp_level_full", bus.o_fifo_level, 2);
      check("bp_rready_low", bus.o_im_rready, 0);
      check("bp_valid", bus.o_du_valid, 1);
      bus.i_im_rvalid = 1'b1;
      bus.i_im_rdata  = 32'h00400493;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("bp_hold_rready%0d", k), bus.o_im_rready, 0);
         check($sformatf("bp_hold_level%0d", k), bus.o_fifo_level, 2);
         check($sformatf("bp_hold_imm%0d", k), bus.o_immediate, 1);
         check($sformatf("bp_hold_rd%0d", k), bus.o_rd_waddr, 6);
      end
      bus.i_ex_ready = 1'b1;
      #1;
      check("bp_reopen", bus.o_im_rready, 1);
      @(negedge clk);
      bus.i_im_rvalid = 1'b0;
      check("bp_out1_valid", bus.o_du_valid, 1);
      check("bp_out1_imm", bus.o_immediate, 2);
      check("bp_out1_level", bus.o_fifo_level, 2);
      @(negedge clk);
      check("bp_out2_imm", bus.o_immediate, 3);
      check("bp_out2_level", bus.o_fifo_level, 1);
      @(negedge clk);
      check("bp_out3_imm", bus.o_immediate, 4);
      check("bp_out3_rd", bus.o_rd_waddr, 9);
      check("bp_out3_level", bus.o_fifo_level, 0);
      @(negedge clk);
      check("bp_drained", bus.o_du_valid, 0);
      for (int r = 6; r <= 9; r++) writeback(5'(r), 32'd0);

      // Flush with two buffered words and one pending issue.
      bus.i_ex_ready = 1'b0;
      push_word(32'h00100513);
      push_word(32'h00200593);
      push_word(32'h00300613);
      check("fl_pre_level", bus.o_fifo_level, 2);
      check("fl_pre_valid", bus.o_du_valid, 1);
      bus.i_flush = 1'b1;
      bus.i_im_rvalid = 1'b1;
      bus.i_im_rdata  = 32'h00400693;
      bus.i_rf_rd_wvalid = 1'b1;
      bus.i_rf_rd_waddr  = 5'd13;
      bus.i_rf_rd_wdata  = 32'h0000ABCD;
      @(negedge clk);
      bus.i_flush = 1'b0;
      bus.i_im_rvalid = 1'b0;
      bus.i_rf_rd_wvalid = 1'b0;
      check("fl_valid", bus.o_du_valid, 0);
      check("fl_level", bus.o_fifo_level, 0);
      bus.i_ex_ready = 1'b1;
      push_word(32'h00D50733);
      wait_valid(4, "fl_busy_clear");
      check("fl_add_rs1", bus.o_rs1_rdata, 0);
      check("fl_add_rs2", bus.o_rs2_rdata, 32'h0000ABCD);
      check("fl_add_rd", bus.o_rd_waddr, 14);
      writeback(5'd14, 32'd0);

      // RV32E: register index 17 is illegal, a low-register ADDI is not.
      bus_e.i_im_rvalid = 1'b1;
      bus_e.i_im_rdata  = 32'h000008B3;
      @(negedge clk);
      bus_e.i_im_rvalid = 1'b0;
      @(negedge clk);
      check("e_x17_valid", bus_e.o_du_valid, 1);
      check("e_x17_illegal", bus_e.o_illegal, 1);
      check("e_x17_rd_wen", bus_e.o_rd_wen, 0);
      bus_e.i_im_rvalid = 1'b1;
      bus_e.i_im_rdata  = 32'h00500093;
      @(negedge clk);
      bus_e.i_im_rvalid = 1'b0;
      @(negedge clk);
      check("e_addi_valid", bus_e.o_du_valid, 1);
      check("e_addi_illegal", bus_e.o_illegal, 0);
      check("e_addi_rd_wen", bus_e.o_rd_wen, 1);

      // Asynchronous reset between clock edges.
      bus.i_ex_ready = 1'b0;
      push_word(32'h00100313);
      push_word(32'h00200393);
      check("ar_pre_valid", bus.o_du_valid, 1);
      #2;
      rstn = 1'b0;
      #1;
      check("ar_valid", bus.o_du_valid, 0);
      check("ar_level", bus.o_fifo_level, 0);
      check("ar_rready", bus.o_im_rready, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
